// File: rtl/frame_sync_filter.sv
// frame_sync_filter
// Multi-channel synchroniser for asynchronous camera status lines. Each
// channel runs through a flop chain, then an optional stability filter. The
// block reports the settled level and one-cycle rise/fall pulses. Channel 0
// also drives a wrapping count of its rising edges, used as a frame counter.
//
// Filter behaviour: Sync_o moves to the synchronised value only after that
// value has disagreed with Sync_o on FILTER_CYCLES consecutive edges. The
// same rule applies in both directions. A mismatch that lasts fewer edges
// is dropped, and the run count starts again at the next mismatch.

module frame_sync_filter #(
    parameter int                    CHANNELS      = 4,
    parameter int                    STAGES        = 3,
    parameter int                    FILTER_CYCLES = 0,
    parameter logic [CHANNELS-1:0]   RESET_VALUE   = '0,
    parameter int                    COUNT_WIDTH   = 16
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic [CHANNELS-1:0]      Async_i,
    input  logic                     Clear_i,
    output logic [CHANNELS-1:0]      Sync_o,
    output logic [CHANNELS-1:0]      Rise_o,
    output logic [CHANNELS-1:0]      Fall_o,
    output logic [COUNT_WIDTH-1:0]   Event_Count_o
);

    // Synchroniser chain, all channels side by side; stage 0 faces the async domain
    logic [CHANNELS-1:0] stage_q [STAGES];
    logic [CHANNELS-1:0] s_w;
    logic [CHANNELS-1:0] sync_w;
    logic [CHANNELS-1:0] prev_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Shift the raw inputs through the chain with no logic between stages
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RESET_VALUE;
            end
        end else begin
            stage_q[0] <= Async_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign s_w = stage_q[STAGES-1];

    genvar gi;
    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            // No filter, so the last chain stage is the synchronised level
            assign sync_w = s_w;
        end else begin : g_filter
            localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);

            for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
                logic [CW-1:0] cnt_q;
                logic [CW-1:0] cnt_d;
                logic          sync_q;
                logic          sync_d;

                // Count mismatch edges; accept the new level when the count reaches the end
                always_comb begin
                    cnt_d  = cnt_q;
                    sync_d = sync_q;
                    if (s_w[gi] == sync_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == C_LAST) begin
                        sync_d = s_w[gi];
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                // Filter state register; reset throws away any partial count
                always_ff @(posedge Clk_i or negedge Reset_i) begin
                    if (!Reset_i) begin
                        cnt_q  <= '0;
                        sync_q <= RESET_VALUE[gi];
                    end else begin
                        cnt_q  <= cnt_d;
                        sync_q <= sync_d;
                    end
                end

                assign sync_w[gi] = sync_q;
            end
        end
    endgenerate

    // Keep last cycle's level so edges decode straight from register outputs
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= sync_w;
        end
    end

    assign Sync_o = sync_w;
    assign Rise_o = sync_w & ~prev_q;
    assign Fall_o = ~sync_w & prev_q;

    // Frame counter next state: clear wins over a coincident rising edge
    always_comb begin
        count_d = count_q;
        if (Clear_i) begin
            count_d = '0;
        end else if (Rise_o[0]) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Frame counter register; wraps naturally at 2^COUNT_WIDTH
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Event_Count_o = count_q;

endmodule

// File: tb/tb_frame_sync_filter.sv
// Testbench for frame_sync_filter. Three instances with different chain
// depths and filter lengths share one set of stimulus. A queue-free
// behavioural model built on delay lines and mismatch run lengths predicts
// every output, and literal checks fix the key latencies and boundaries.

module tb_frame_sync_filter;

    localparam int N = 3;
    localparam int STG [N] = '{3, 2, 5};
    localparam int FLT [N] = '{0, 1, 4};
    localparam logic [3:0]  RSTV  [N] = '{4'b0101, 4'b0000, 4'b0000};
    localparam logic [15:0] CMASK [N] = '{16'hFFFF, 16'h000F, 16'h000F};

    logic       Clk_i;
    logic       Reset_i;
    logic [3:0] Async_i;
    logic       Clear_i;

    logic [3:0]  sync_a, rise_a, fall_a;
    logic [3:0]  sync_b, rise_b, fall_b;
    logic [3:0]  sync_c, rise_c, fall_c;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b, cnt_c;

    logic [3:0]  d_sync [N];
    logic [3:0]  d_rise [N];
    logic [3:0]  d_fall [N];
    logic [15:0] d_cnt  [N];

    int checks = 0;
    int errors = 0;
    int printed = 0;

    frame_sync_filter #(.CHANNELS(4), .STAGES(3), .FILTER_CYCLES(0),
                        .RESET_VALUE(4'b0101), .COUNT_WIDTH(16)) u_a (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .Async_i(Async_i), .Clear_i(Clear_i),
        .Sync_o(sync_a), .Rise_o(rise_a), .Fall_o(fall_a), .Event_Count_o(cnt_a));

    frame_sync_filter #(.CHANNELS(4), .STAGES(2), .FILTER_CYCLES(1),
                        .RESET_VALUE(4'b0000), .COUNT_WIDTH(4)) u_b (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .Async_i(Async_i), .Clear_i(Clear_i),
        .Sync_o(sync_b), .Rise_o(rise_b), .Fall_o(fall_b), .Event_Count_o(cnt_b));

    frame_sync_filter #(.CHANNELS(4), .STAGES(5), .FILTER_CYCLES(4),
                        .RESET_VALUE(4'b0000), .COUNT_WIDTH(4)) u_c (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .Async_i(Async_i), .Clear_i(Clear_i),
        .Sync_o(sync_c), .Rise_o(rise_c), .Fall_o(fall_c), .Event_Count_o(cnt_c));

    always_comb begin
        d_sync[0] = sync_a; d_rise[0] = rise_a; d_fall[0] = fall_a; d_cnt[0] = cnt_a;
        d_sync[1] = sync_b; d_rise[1] = rise_b; d_fall[1] = fall_b; d_cnt[1] = {12'd0, cnt_b};
        d_sync[2] = sync_c; d_rise[2] = rise_c; d_fall[2] = fall_c; d_cnt[2] = {12'd0, cnt_c};
    end

    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    // ---------------- behavioural model ----------------
    logic [3:0]  m_dl   [N][8];
    logic [3:0]  m_sync [N];
    logic [3:0]  m_prev [N];
    logic [3:0]  m_rise [N];
    logic [3:0]  m_fall [N];
    logic [15:0] m_cnt  [N];
    int          m_run  [N][4];
    bit          m_valid = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) m_dl[i][k] = RSTV[i];
            m_sync[i] = RSTV[i];
            m_prev[i] = RSTV[i];
            m_rise[i] = 4'b0;
            m_fall[i] = 4'b0;
            m_cnt[i]  = 16'd0;
            for (int c = 0; c < 4; c++) m_run[i][c] = 0;
        end
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            logic [3:0] s_old;
            logic [3:0] s_new;
            logic [3:0] sync_old;
            s_old    = m_dl[i][STG[i]-1];
            sync_old = m_sync[i];
            if (Clear_i) m_cnt[i] = 16'd0;
            else if (m_rise[i][0]) m_cnt[i] = (m_cnt[i] + 16'd1) & CMASK[i];
            for (int k = 7; k > 0; k--) m_dl[i][k] = m_dl[i][k-1];
            m_dl[i][0] = Async_i;
            s_new = m_dl[i][STG[i]-1];
            if (FLT[i] == 0) begin
                m_sync[i] = s_new;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (s_old[c] != sync_old[c]) begin
                        m_run[i][c]++;
                        if (m_run[i][c] == FLT[i]) begin
                            m_sync[i][c] = s_old[c];
                            m_run[i][c]  = 0;
                        end
                    end else begin
                        m_run[i][c] = 0;
                    end
                end
            end
            m_prev[i] = sync_old;
            m_rise[i] = m_sync[i] & ~m_prev[i];
            m_fall[i] = ~m_sync[i] & m_prev[i];
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk_i or negedge Reset_i);
            if (!Reset_i) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic report(input string nm, input logic [15:0] act, input logic [15:0] exp);
        errors++;
        if (printed < 40) begin
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
            printed++;
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk_i);
            if (m_valid) begin
                for (int i = 0; i < N; i++) begin
                    checks += 4;
                    if (d_sync[i] !== m_sync[i]) report($sformatf("model_sync[%0d]", i), {12'd0, d_sync[i]}, {12'd0, m_sync[i]});
                    if (d_rise[i] !== m_rise[i]) report($sformatf("model_rise[%0d]", i), {12'd0, d_rise[i]}, {12'd0, m_rise[i]});
                    if (d_fall[i] !== m_fall[i]) report($sformatf("model_fall[%0d]", i), {12'd0, d_fall[i]}, {12'd0, m_fall[i]});
                    if (d_cnt[i]  !== m_cnt[i])  report($sformatf("model_cnt[%0d]", i), d_cnt[i], m_cnt[i]);
                end
            end
        end
    end

    // ---------------- literal checks and stimulus ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) report(nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk_i);
        #1;
    endtask

    int  first [N];
    int  rcnt  [N];
    int  hi_seen, rise_seen, fall_seen;
    bit  found;
    logic [3:0] base [N];

    initial begin
        Reset_i = 1'b0;
        Async_i = 4'b1010;
        Clear_i = 1'b0;

        // Reset defaults with inputs opposing the reset level
        step(3);
        chk("reset_sync_a", {12'd0, sync_a}, 16'h0005);
        chk("reset_rise_a", {12'd0, rise_a}, 16'h0000);
        chk("reset_fall_a", {12'd0, fall_a}, 16'h0000);
        chk("reset_cnt_a",  cnt_a, 16'h0000);
        chk("reset_sync_c", {12'd0, sync_c}, 16'h0000);
        Reset_i = 1'b1;
        step(2);
        chk("release_edge2_sync_a", {12'd0, sync_a}, 16'h0005);
        step(1);
        chk("release_edge3_sync_a", {12'd0, sync_a}, 16'h000A);
        chk("release_edge3_rise_a", {12'd0, rise_a}, 16'h000A);
        chk("release_edge3_fall_a", {12'd0, fall_a}, 16'h0005);
        step(1);
        chk("release_edge4_rise_a", {12'd0, rise_a}, 16'h0000);
        chk("release_edge4_fall_a", {12'd0, fall_a}, 16'h0000);
        $display("phase reset: done");

        // Latency sweep on channel 2
        step(20);
        for (int i = 0; i < N; i++) begin
            first[i] = 0; rcnt[i] = 0; base[i] = d_sync[i];
        end
        Async_i = 4'b1110;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            for (int i = 0; i < N; i++) begin
                if (first[i] == 0 && d_sync[i][2]) first[i] = e;
                if (d_rise[i][2]) rcnt[i]++;
            end
        end
        chk("latency_a", 16'(first[0]), 16'd3);
        chk("latency_b", 16'(first[1]), 16'd3);
        chk("latency_c", 16'(first[2]), 16'd9);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("latency_rise_pulses[%0d]", i), 16'(rcnt[i]), 16'd1);
            chk($sformatf("latency_others_static[%0d]", i), {12'd0, d_sync[i] & 4'b1011}, {12'd0, base[i] & 4'b1011});
        end
        $display("phase latency: done");

        // Glitch filter on channel 1 of the F=4 instance
        Async_i = 4'b0100;
        step(20);
        hi_seen = 0; rise_seen = 0; fall_seen = 0;
        for (int w = 1; w <= 3; w++) begin
            Async_i[1] = 1'b1;
            for (int k = 0; k < w; k++) begin
                step(1);
                if (sync_c[1]) hi_seen++;
                if (rise_c[1]) rise_seen++;
            end
            Async_i[1] = 1'b0;
            for (int k = 0; k < 15; k++) begin
                step(1);
                if (sync_c[1]) hi_seen++;
                if (rise_c[1]) rise_seen++;
            end
        end
        chk("glitch_short_high", 16'(hi_seen), 16'd0);
        chk("glitch_short_rise", 16'(rise_seen), 16'd0);
        rise_seen = 0; fall_seen = 0;
        Async_i[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (rise_c[1]) rise_seen++;
            if (fall_c[1]) fall_seen++;
        end
        Async_i[1] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (rise_c[1]) rise_seen++;
            if (fall_c[1]) fall_seen++;
        end
        chk("glitch_long_rise", 16'(rise_seen), 16'd1);
        chk("glitch_long_fall", 16'(fall_seen), 16'd1);
        $display("phase glitch: done");

        // Counter wrap: 17 frames on channel 0
        Clear_i = 1'b1;
        step(1);
        Clear_i = 1'b0;
        for (int p = 0; p < 17; p++) begin
            Async_i[0] = 1'b1;
            step(6);
            Async_i[0] = 1'b0;
            step(6);
        end
        step(20);
        chk("count_a_17", cnt_a, 16'd17);
        chk("count_b_wrap", {12'd0, cnt_b}, 16'd1);
        chk("count_c_wrap", {12'd0, cnt_c}, 16'd1);
        $display("phase counter wrap: done");

        // Clear coinciding with a channel-0 rise on the F=1 instance
        found = 1'b0;
        Async_i[0] = 1'b1;
        for (int k = 0; k < 30 && !found; k++) begin
            step(1);
            if (rise_b[0]) begin
                Clear_i = 1'b1;
                step(1);
                Clear_i = 1'b0;
                chk("clear_wins_b", {12'd0, cnt_b}, 16'd0);
                found = 1'b1;
            end
        end
        if (!found) report("clear_wait_timeout", 16'd0, 16'd1);
        Async_i[0] = 1'b0;
        step(20);
        $display("phase clear: done");

        // Reset in the middle of a filter run on channel 3
        Async_i[3] = 1'b1;
        step(7);
        Reset_i = 1'b0;
        step(2);
        Reset_i = 1'b1;
        chk("midreset_sync_c", {12'd0, sync_c}, 16'd0);
        chk("midreset_cnt_c", {12'd0, cnt_c}, 16'd0);
        first[2] = 0;
        for (int e = 1; e <= 14; e++) begin
            step(1);
            if (first[2] == 0 && sync_c[3]) first[2] = e;
        end
        chk("midreset_latency_c", 16'(first[2]), 16'd9);
        $display("phase mid reset: done");

        // Randomised traffic against the model
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 5) == 0) Async_i[$urandom_range(0, 3)] ^= 1'b1;
            Clear_i = ($urandom_range(0, 63) == 0);
            step(1);
        end
        Clear_i = 1'b0;
        step(20);
        $display("phase random: done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
